output_display_module: RTL and testbench

Output-side counterpart of the keypad input module. It accepts the 14-bit binary result produced by the datapath and converts it to four BCD digits using a sequential double-dabble (shift-add-3) algorithm, one bit per clock. It then drives a 4-digit multiplexed seven-segment display from the converted value. It sits at the display end of the calculator datapath, between the result register and the board display pins.

---
 rtl/display_pkg.sv | 34 +++
 rtl/output_display_module_seven_seg_decoder.sv | 30 +++
 rtl/output_display_module.sv | 147 ++++++++++++++
 tb/tb_output_display_module.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants, FSM state type, segment patterns and the double-dabble step
// used by the output display path.
package display_pkg;
  localparam int BIN_W   = 14;
  localparam int DIGITS  = 4;
  localparam int MAX_VAL = 9999;
  localparam int SHIFT_W = 4 * DIGITS + BIN_W;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // One shift-add-3 iteration: nibbles are corrected independently, no carry between them.
  function automatic logic [SHIFT_W-1:0] dabble_step(input logic [SHIFT_W-1:0] s);
    logic [SHIFT_W-1:0] t;
    t = s;
    for (int k = 0; k < DIGITS; k++) begin
      if (t[BIN_W+4*k +: 4] >= 4'd5)
        t[BIN_W+4*k +: 4] = t[BIN_W+4*k +: 4] + 4'd3;
    end
    return {t[SHIFT_W-2:0], 1'b0};
  endfunction
endpackage

// File: rtl/output_display_module_seven_seg_decoder.sv
// Combinational BCD nibble to active-high {g,f,e,d,c,b,a} segment decoder.
module seven_seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end
endmodule

// File: rtl/output_display_module.sv
// Sequential binary-to-BCD converter (one bit per clock) driving a 4-digit
// multiplexed seven-segment display from the last converted value.
module output_display_module
  import display_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [13:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] bcd_out,
  output logic [6:0]  seg,
  output logic [3:0]  digit_sel
);
  localparam int                 CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]   REF_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [BIN_W-1:0]   MAX_BIN  = BIN_W'(MAX_VAL);
  localparam logic [3:0]         LAST_BIT = 4'(BIN_W - 1);

  state_e              state_q, state_d;
  logic [SHIFT_W-1:0]  shreg_q, shreg_d, shift_next;
  logic [3:0]          bitcnt_q, bitcnt_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         bcd_q, bcd_d;
  logic [CNT_W-1:0]    refresh_q, refresh_d;
  logic [DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic [3:0]          nibble;
  logic                blank;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    bcd_d      = bcd_q;
    shift_next = dabble_step(shreg_q);
    unique case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d    = {{(4*DIGITS){1'b0}}, bin_in};
          ovf_pend_d = (bin_in > MAX_BIN);
          bitcnt_d   = 4'd0;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d  = shift_next;
        bitcnt_d = bitcnt_q + 4'd1;
        // Results are published on the final shift so they are valid in the DONE cycle.
        if (bitcnt_q == LAST_BIT) begin
          busy_d     = 1'b0;
          done_d     = 1'b1;
          overflow_d = ovf_pend_q;
          bcd_d      = ovf_pend_q ? 16'h9999 : shift_next[SHIFT_W-1:BIN_W];
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (refresh_q == REF_LAST) begin
      refresh_d   = '0;
      digit_sel_d = {digit_sel_q[DIGITS-2:0], digit_sel_q[DIGITS-1]};
    end else begin
      refresh_d   = refresh_q + 1'b1;
      digit_sel_d = digit_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      bcd_q       <= 16'h0000;
      refresh_q   <= '0;
      digit_sel_q <= DIGITS'(1);
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      bcd_q       <= bcd_d;
      refresh_q   <= refresh_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  // Conversion scratch state is only meaningful once IDLE has loaded it.
  always_ff @(posedge clk) begin
    shreg_q    <= shreg_d;
    bitcnt_q   <= bitcnt_d;
    ovf_pend_q <= ovf_pend_d;
  end

  always_comb begin
    nibble = bcd_q[3:0];
    blank  = 1'b0;
    case (digit_sel_q)
      4'b0010: begin
        nibble = bcd_q[7:4];
        blank  = BLANK_LEADING && (bcd_q[15:4] == 12'h000);
      end
      4'b0100: begin
        nibble = bcd_q[11:8];
        blank  = BLANK_LEADING && (bcd_q[15:8] == 8'h00);
      end
      4'b1000: begin
        nibble = bcd_q[15:12];
        blank  = BLANK_LEADING && (bcd_q[15:12] == 4'h0);
      end
      default: begin
        nibble = bcd_q[3:0];
        blank  = 1'b0;
      end
    endcase
  end

  seven_seg_decoder u_dec (
    .nibble (nibble),
    .blank  (blank),
    .dash   (overflow_q),
    .seg    (seg)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign bcd_out   = bcd_q;
  assign digit_sel = digit_sel_q;
endmodule

// File: tb/tb_output_display_module.sv
// Directed bench for output_display_module: table of conversions plus
// hand-written sequences for ignored loads and reset during conversion.
module tb_output_display_module;
  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] bcd_out;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
    logic [27:0] segs;   // {thousands, hundreds, tens, units}
  } vec_t;

  vec_t vecs[7];

  output_display_module #(
    .REFRESH_DIV   (4),
    .BLANK_LEADING (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .bcd_out   (bcd_out),
    .seg       (seg),
    .digit_sel (digit_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse load for one edge, then follow the conversion until done (bounded).
  task automatic do_load(input logic [13:0] v, output int lat, output int nbusy);
    @(negedge clk);
    load   = 1'b1;
    bin_in = v;
    @(negedge clk);
    load  = 1'b0;
    lat   = 0;
    nbusy = 0;
    for (int c = 1; c <= 40; c++) begin
      if (busy) nbusy++;
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_scan(input logic [27:0] exp, input string tag);
    int         seen[4];
    logic [3:0] hit;
    hit = 4'b0000;
    for (int i = 0; i < 4; i++) seen[i] = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (digit_sel)
        4'b0001: begin seen[0] = int'(seg); hit[0] = 1'b1; end
        4'b0010: begin seen[1] = int'(seg); hit[1] = 1'b1; end
        4'b0100: begin seen[2] = int'(seg); hit[2] = 1'b1; end
        4'b1000: begin seen[3] = int'(seg); hit[3] = 1'b1; end
        default: ;
      endcase
    end
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_seg%0d", tag, k), hit[k] ? seen[k] : -1, int'(exp[7*k +: 7]));
  endtask

  initial begin
    int lat, nbusy, ndone;

    vecs[0] = '{14'd1234,  16'h1234, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}};
    vecs[1] = '{14'd9999,  16'h9999, 1'b0, {7'h6F, 7'h6F, 7'h6F, 7'h6F}};
    vecs[2] = '{14'd16383, 16'h9999, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[3] = '{14'd0,     16'h0000, 1'b0, {7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[4] = '{14'd7,     16'h0007, 1'b0, {7'h00, 7'h00, 7'h00, 7'h07}};
    vecs[5] = '{14'd10000, 16'h9999, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[6] = '{14'd1005,  16'h1005, 1'b0, {7'h06, 7'h3F, 7'h3F, 7'h6D}};

    rst    = 1'b1;
    load   = 1'b1;
    bin_in = 14'd1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_bcd", bcd_out, 16'h0000);
    check("rst_dsel", digit_sel, 4'b0001);
    check("rst_seg", seg, 7'h3F);
    rst  = 1'b0;
    load = 1'b0;

    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 3)  check("scan_hold3", digit_sel, 4'b0001);
      if (i == 4)  check("scan_rot4", digit_sel, 4'b0010);
      if (i == 8)  check("scan_rot8", digit_sel, 4'b0100);
      if (i == 12) check("scan_rot12", digit_sel, 4'b1000);
      if (i == 16) check("scan_wrap16", digit_sel, 4'b0001);
    end

    for (int v = 0; v < 7; v++) begin
      do_load(vecs[v].bin, lat, nbusy);
      check($sformatf("v%0d_latency", v), lat, 15);
      check($sformatf("v%0d_busycycles", v), nbusy, 14);
      check($sformatf("v%0d_bcd", v), bcd_out, vecs[v].bcd);
      check($sformatf("v%0d_ovf", v), overflow, vecs[v].ovf);
      check_scan(vecs[v].segs, $sformatf("v%0d", v));
    end

    // Loads during SHIFT and DONE must be ignored.
    @(negedge clk);
    load   = 1'b1;
    bin_in = 14'd42;
    ndone  = 0;
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      if (done) ndone++;
      load   = (e == 3 || e == 14 || e == 15);
      bin_in = load ? 14'd77 : 14'd42;
    end
    load = 1'b0;
    check("ign_done_count", ndone, 1);
    check("ign_bcd", bcd_out, 16'h0042);
    check("ign_busy", busy, 0);
    check_scan({7'h00, 7'h00, 7'h66, 7'h5B}, "ign");

    // Reset in the middle of a conversion aborts it.
    @(negedge clk);
    load   = 1'b1;
    bin_in = 14'd5000;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_bcd", bcd_out, 16'h0000);
    check("abort_dsel", digit_sel, 4'b0001);
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", ndone, 0);

    do_load(14'd321, lat, nbusy);
    check("post_latency", lat, 15);
    check("post_bcd", bcd_out, 16'h0321);
    check("post_ovf", overflow, 0);
    check_scan({7'h00, 7'h4F, 7'h5B, 7'h06}, "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
